pq_shift_array: RTL and testbench

- Parametrised shift-register hardware priority queue storing <key,value> pairs.
- Successor to the fixed-width package types: key width, value width, capacity and ordering direction are generics.
- Uses per-slot valid bits, so no key value is reserved as an empty sentinel.
- Sits behind HWPQ clients (schedulers, test harness) as a drop-in enqueue/dequeue engine with a registered head output.

---
 rtl/pq_shift_array.sv | 137 +++++++++++++
 tb/tb_pq_shift_array.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pq_shift_array.sv
// Shift-register priority queue of <key,val> pairs with per-slot valid bits.
// Enqueue, dequeue or both complete in one cycle; the head is slot 0's registers.
module pq_shift_array #(
    parameter int KEY_WIDTH = 8,
    parameter int VAL_WIDTH = 8,
    parameter int CAPACITY  = 63,
    parameter int MAX_FIRST = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enq,
    input  logic [KEY_WIDTH-1:0]          key_in,
    input  logic [VAL_WIDTH-1:0]          val_in,
    input  logic                          deq,
    output logic [KEY_WIDTH-1:0]          key_out,
    output logic [VAL_WIDTH-1:0]          val_out,
    output logic                          head_valid,
    output logic [$clog2(CAPACITY+1)-1:0] count,
    output logic                          full,
    output logic                          empty,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int IW = $clog2(CAPACITY + 1);
    localparam int SW = $clog2(CAPACITY);

    logic                 vld_q [CAPACITY];
    logic [KEY_WIDTH-1:0] key_q [CAPACITY];
    logic [VAL_WIDTH-1:0] val_q [CAPACITY];

    logic                 vld_n [CAPACITY];
    logic [KEY_WIDTH-1:0] key_n [CAPACITY];
    logic [VAL_WIDTH-1:0] val_n [CAPACITY];

    // Copies padded with an always-empty slot at index CAPACITY, so shifts need no edge cases
    logic                 vld_x [CAPACITY+1];
    logic [KEY_WIDTH-1:0] key_x [CAPACITY+1];
    logic [VAL_WIDTH-1:0] val_x [CAPACITY+1];

    logic [CAPACITY:0] ins;
    logic [IW-1:0]     pos;
    logic [IW-1:0]     pos1;
    logic [IW-1:0]     cnt_n;
    logic              op_ins;
    logic              op_del;
    logic              op_both;

    function automatic logic beats(input logic [KEY_WIDTH-1:0] a,
                                   input logic [KEY_WIDTH-1:0] b);
        return (MAX_FIRST != 0) ? (a > b) : (a < b);
    endfunction

    assign op_both = enq & deq & ~empty;
    assign op_ins  = enq & ~op_both & (deq | ~full);
    assign op_del  = deq & ~enq & ~empty;
    assign cnt_n   = count + IW'(op_ins) - IW'(op_del);

    always_comb begin
        ins = '0;
        for (int i = 0; i < CAPACITY; i++) begin
            vld_x[IW'(i)] = vld_q[SW'(i)];
            key_x[IW'(i)] = key_q[SW'(i)];
            val_x[IW'(i)] = val_q[SW'(i)];
            ins[IW'(i)]   = ~vld_q[SW'(i)] | beats(key_in, key_q[SW'(i)]);
        end
        vld_x[IW'(CAPACITY)] = 1'b0;
        key_x[IW'(CAPACITY)] = '0;
        val_x[IW'(CAPACITY)] = '0;
        ins[IW'(CAPACITY)]   = 1'b1;
    end

    // pos: first insertable slot overall; pos1: same search restricted to slots 1 and up
    always_comb begin
        pos  = IW'(CAPACITY);
        pos1 = IW'(CAPACITY);
        for (int i = CAPACITY - 1; i >= 0; i--) begin
            if (ins[IW'(i)]) begin
                pos = IW'(i);
                if (i >= 1) pos1 = IW'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CAPACITY; i++) begin
            vld_n[SW'(i)] = vld_q[SW'(i)];
            key_n[SW'(i)] = key_q[SW'(i)];
            val_n[SW'(i)] = val_q[SW'(i)];
            if (op_del || (op_both && (IW'(i + 1) < pos1))) begin
                vld_n[SW'(i)] = vld_x[IW'(i + 1)];
                key_n[SW'(i)] = key_x[IW'(i + 1)];
                val_n[SW'(i)] = val_x[IW'(i + 1)];
            end else if ((op_ins && (IW'(i) == pos)) || (op_both && (IW'(i + 1) == pos1))) begin
                vld_n[SW'(i)] = 1'b1;
                key_n[SW'(i)] = key_in;
                val_n[SW'(i)] = val_in;
            end else if (op_ins && (IW'(i) > pos)) begin
                vld_n[SW'(i)] = vld_x[IW'((i == 0) ? 0 : i - 1)];
                key_n[SW'(i)] = key_x[IW'((i == 0) ? 0 : i - 1)];
                val_n[SW'(i)] = val_x[IW'((i == 0) ? 0 : i - 1)];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CAPACITY; i++) begin
                vld_q[SW'(i)] <= 1'b0;
                key_q[SW'(i)] <= '0;
                val_q[SW'(i)] <= '0;
            end
            count     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            for (int i = 0; i < CAPACITY; i++) begin
                vld_q[SW'(i)] <= vld_n[SW'(i)];
                key_q[SW'(i)] <= key_n[SW'(i)];
                val_q[SW'(i)] <= val_n[SW'(i)];
            end
            count     <= cnt_n;
            full      <= (cnt_n == IW'(CAPACITY));
            empty     <= (cnt_n == '0);
            overflow  <= enq & ~deq & full;
            underflow <= deq & empty;
        end
    end

    // Vacated slots always load zeros, so slot 0 reads 0 whenever it is invalid
    assign key_out    = key_q[0];
    assign val_out    = val_q[0];
    assign head_valid = vld_q[0];

endmodule

// File: tb/tb_pq_shift_array.sv
// Bench for pq_shift_array: a min-queue and a max-queue (capacity 4) checked
// every cycle against a sorted-list model, plus hand-computed head values.
module tb_pq_shift_array;

    localparam int CAP = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       ea = 1'b0, da = 1'b0, eb = 1'b0, db = 1'b0;
    logic [7:0] ka = '0, va = '0, kb = '0, vb = '0;
    logic [7:0] koa, voa, kob, vob;
    logic       hva, hvb, fa, fb, ema, emb, ova, ovb, una, unb;
    logic [2:0] ca, cb;

    pq_shift_array #(.KEY_WIDTH(8), .VAL_WIDTH(8), .CAPACITY(CAP), .MAX_FIRST(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .enq(ea), .key_in(ka), .val_in(va), .deq(da),
        .key_out(koa), .val_out(voa), .head_valid(hva), .count(ca), .full(fa),
        .empty(ema), .overflow(ova), .underflow(una));

    pq_shift_array #(.KEY_WIDTH(8), .VAL_WIDTH(8), .CAPACITY(CAP), .MAX_FIRST(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .enq(eb), .key_in(kb), .val_in(vb), .deq(db),
        .key_out(kob), .val_out(vob), .head_valid(hvb), .count(cb), .full(fb),
        .empty(emb), .overflow(ovb), .underflow(unb));

    int tests = 0;
    int fails = 0;
    int mk[2][$];
    int mv[2][$];
    bit eov[2] = '{1'b0, 1'b0};
    bit eun[2] = '{1'b0, 1'b0};

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model: remove head first, then place the new element behind every
    // element that it does not strictly beat.
    task automatic mstep(input int d, input bit e, input int k, input int v, input bit q);
        int pos;
        eov[d] = 1'b0;
        eun[d] = 1'b0;
        if (q) begin
            if (mk[d].size() == 0) eun[d] = 1'b1;
            else begin
                mk[d].delete(0);
                mv[d].delete(0);
            end
        end
        if (e) begin
            if (mk[d].size() == CAP) eov[d] = 1'b1;
            else begin
                pos = 0;
                foreach (mk[d][i]) begin
                    if (!((d == 0) ? (k < mk[d][i]) : (k > mk[d][i]))) pos++;
                end
                mk[d].insert(pos, k);
                mv[d].insert(pos, v);
            end
        end
    endtask

    task automatic mclear();
        for (int d = 0; d < 2; d++) begin
            mk[d].delete();
            mv[d].delete();
            eov[d] = 1'b0;
            eun[d] = 1'b0;
        end
    endtask

    task automatic cmp(input int d, input logic [7:0] ko, input logic [7:0] vo, input logic hv,
                       input logic [2:0] c, input logic fu, input logic em,
                       input logic ov, input logic un);
        int n;
        n = mk[d].size();
        chk($sformatf("q%0d.key_out", d), int'(ko), (n > 0) ? mk[d][0] : 0);
        chk($sformatf("q%0d.val_out", d), int'(vo), (n > 0) ? mv[d][0] : 0);
        chk($sformatf("q%0d.head_valid", d), int'(hv), (n > 0) ? 1 : 0);
        chk($sformatf("q%0d.count", d), int'(c), n);
        chk($sformatf("q%0d.full", d), int'(fu), (n == CAP) ? 1 : 0);
        chk($sformatf("q%0d.empty", d), int'(em), (n == 0) ? 1 : 0);
        chk($sformatf("q%0d.overflow", d), int'(ov), int'(eov[d]));
        chk($sformatf("q%0d.underflow", d), int'(un), int'(eun[d]));
    endtask

    always @(negedge clk) begin
        cmp(0, koa, voa, hva, ca, fa, ema, ova, una);
        cmp(1, kob, vob, hvb, cb, fb, emb, ovb, unb);
    end

    task automatic cyc(input int d, input bit e, input int k, input int v, input bit q);
        if (d == 0) begin
            ea = e; ka = k[7:0]; va = v[7:0]; da = q;
        end else begin
            eb = e; kb = k[7:0]; vb = v[7:0]; db = q;
        end
        @(posedge clk);
        if (rst_n) begin
            mstep(0, (d == 0) && e, k, v, (d == 0) && q);
            mstep(1, (d == 1) && e, k, v, (d == 1) && q);
        end
        @(negedge clk);
        ea = 1'b0; da = 1'b0; eb = 1'b0; db = 1'b0;
    endtask

    int exp_k[3];
    int exp_v[3];

    initial begin
        mclear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("reset.empty", int'(ema), 1);
        chk("reset.count", int'(ca), 0);
        chk("reset.head_valid", int'(hva), 0);
        chk("reset.key_out", int'(koa), 0);
        chk("reset.overflow", int'(ova), 0);
        chk("reset.underflow", int'(una), 0);

        // sorted insert
        cyc(0, 1, 30, 'hA, 0);
        cyc(0, 1, 10, 'hB, 0);
        chk("sort.head_key", int'(koa), 10);
        chk("sort.head_val", int'(voa), 'hB);
        cyc(0, 1, 20, 'hC, 0);
        chk("sort.count", int'(ca), 3);
        exp_k = '{10, 20, 30};
        exp_v = '{'hB, 'hC, 'hA};
        for (int i = 0; i < 3; i++) begin
            chk("sort.deq_key", int'(koa), exp_k[i]);
            chk("sort.deq_val", int'(voa), exp_v[i]);
            cyc(0, 0, 0, 0, 1);
        end
        chk("sort.empty", int'(ema), 1);

        // FIFO ties, full and overflow
        for (int v = 1; v <= 4; v++) cyc(0, 1, 5, v, 0);
        chk("tie.full", int'(fa), 1);
        cyc(0, 1, 0, 9, 0);
        chk("ovf.pulse", int'(ova), 1);
        chk("ovf.head_key", int'(koa), 5);
        chk("ovf.head_val", int'(voa), 1);
        cyc(0, 0, 0, 0, 0);
        chk("ovf.pulse_end", int'(ova), 0);
        for (int v = 1; v <= 4; v++) begin
            chk("tie.deq_val", int'(voa), v);
            cyc(0, 0, 0, 0, 1);
        end
        chk("tie.empty", int'(ema), 1);

        // simultaneous enq+deq
        cyc(0, 1, 10, 1, 0);
        cyc(0, 1, 20, 2, 0);
        cyc(0, 1, 30, 3, 0);
        cyc(0, 1, 25, 4, 1);
        chk("both.head_key", int'(koa), 20);
        chk("both.count", int'(ca), 3);
        cyc(0, 1, 5, 5, 1);
        chk("both2.head_key", int'(koa), 5);
        exp_k = '{5, 25, 30};
        for (int i = 0; i < 3; i++) begin
            chk("both.deq_key", int'(koa), exp_k[i]);
            cyc(0, 0, 0, 0, 1);
        end

        // underflow and enq+deq on empty / single element
        cyc(0, 0, 0, 0, 1);
        chk("unf.pulse", int'(una), 1);
        chk("unf.count", int'(ca), 0);
        cyc(0, 1, 7, 'h77, 1);
        chk("unf2.pulse", int'(una), 1);
        chk("unf2.count", int'(ca), 1);
        chk("unf2.head_key", int'(koa), 7);
        cyc(0, 1, 9, 'h99, 1);
        chk("single.head_key", int'(koa), 9);
        chk("single.underflow", int'(una), 0);
        cyc(0, 0, 0, 0, 1);

        // enq+deq while full: no overflow, tie goes to the tail
        for (int v = 1; v <= 4; v++) cyc(0, 1, 5, v, 0);
        cyc(0, 1, 5, 8, 1);
        chk("fullboth.overflow", int'(ova), 0);
        chk("fullboth.head_val", int'(voa), 2);
        chk("fullboth.full", int'(fa), 1);
        repeat (4) cyc(0, 0, 0, 0, 1);

        // max-first queue, then asynchronous reset mid-cycle
        cyc(1, 1, 3, 1, 0);
        cyc(1, 1, 200, 2, 0);
        cyc(1, 1, 50, 3, 0);
        chk("max.head_key", int'(kob), 200);
        chk("max.head_val", int'(vob), 2);
        chk("max.count", int'(cb), 3);
        cyc(0, 1, 40, 4, 0);
        @(posedge clk);
        mstep(0, 0, 0, 0, 0);
        mstep(1, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.key_out", int'(kob), 0);
        chk("arst.head_valid", int'(hvb), 0);
        chk("arst.count", int'(cb), 0);
        chk("arst.empty", int'(emb), 1);
        chk("arst.a_count", int'(ca), 0);
        mclear();
        @(negedge clk);
        cyc(1, 1, 60, 6, 0);
        rst_n = 1'b1;
        cyc(1, 1, 70, 7, 0);
        chk("post.head_key", int'(kob), 70);
        cyc(0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
